alu_issue_ctrl: RTL

- Front-end sequencer for the ALU1 datapath.
- Accepts operation requests through a valid/ready port and buffers them in a small FIFO.
- Drives the ALU control and operand inputs (CMD, MODE, OPA, OPB, CIN, CE, VALID) one operation at a time, waiting the command-dependent latency.
- Captures RES and the flags into a response register with its own valid/ready handshake.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_req_fifo.sv | 54 +++++
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU1 issue controller: command encodings,
// default latencies, FSM states and the captured flag bundle.
package alu_pkg;
  localparam logic [3:0] CMD_ADD     = 4'b0000;
  localparam logic [3:0] CMD_INC_MUL = 4'b1001;
  localparam logic [3:0] CMD_SHL_MUL = 4'b1010;

  localparam int DEF_MUL_LAT  = 2;
  localparam int DEF_BASE_LAT = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } alu_flags_t;

  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && (cmd == CMD_INC_MUL || cmd == CMD_SHL_MUL);
  endfunction
endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO: power-of-two depth, wrapping pointers, occupancy carries the
// extra bit that separates full from empty.
module alu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU1 front-end: buffers requests, issues one op at a time with a
// command-dependent latency and holds the result for a valid/ready consumer.
module alu_issue_ctrl import alu_pkg::*; #(
  parameter int INPUT    = 8,
  parameter int DEPTH    = 4,
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int BASE_LAT = DEF_BASE_LAT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [3:0]               REQ_CMD,
  input  logic                     REQ_MODE,
  input  logic [INPUT-1:0]         REQ_OPA,
  input  logic [INPUT-1:0]         REQ_OPB,
  input  logic                     REQ_CIN,
  input  logic [1:0]               REQ_OPV,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [3:0]               ALU_CMD,
  output logic                     ALU_MODE,
  output logic [INPUT-1:0]         ALU_OPA,
  output logic [INPUT-1:0]         ALU_OPB,
  output logic                     ALU_CIN,
  output logic [1:0]               ALU_VALID,
  output logic                     ALU_CE,
  input  logic [2*INPUT-1:0]       ALU_RES,
  input  logic                     ALU_ERR,
  input  logic                     ALU_OFLOW,
  input  logic                     ALU_COUT,
  input  logic                     ALU_G,
  input  logic                     ALU_L,
  input  logic                     ALU_E,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [2*INPUT-1:0]       RSP_RES,
  output logic                     RSP_ERR,
  output logic                     RSP_OFLOW,
  output logic                     RSP_COUT,
  output logic                     RSP_G,
  output logic                     RSP_L,
  output logic                     RSP_E
);
  localparam int RW = 2*INPUT + 8;
  localparam int CW = $clog2((MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT) + 1;

  logic [RW-1:0]    fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [3:0]       h_cmd;
  logic             h_mode, h_cin;
  logic [INPUT-1:0] h_opa, h_opb;
  logic [1:0]       h_opv;
  alu_flags_t       in_flags;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             mode_q, mode_d, cin_q, cin_d, ce_q, ce_d;
  logic [INPUT-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]       opv_q, opv_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2*INPUT-1:0] rsp_res_q, rsp_res_d;
  alu_flags_t       rsp_flags_q, rsp_flags_d;

  assign fifo_wdata = {REQ_CMD, REQ_MODE, REQ_OPA, REQ_OPB, REQ_CIN, REQ_OPV};
  assign {h_cmd, h_mode, h_opa, h_opb, h_cin, h_opv} = fifo_rdata;
  assign in_flags   = {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E};
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign REQ_READY  = !fifo_full;

  alu_req_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK), .rst(RST), .push(REQ_VALID), .pop(fifo_pop),
    .wdata(fifo_wdata), .rdata(fifo_rdata), .level(LEVEL),
    .full(fifo_full), .empty(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    mode_d      = mode_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cin_d       = cin_q;
    opv_d       = opv_q;
    ce_d        = ce_q;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        {cmd_d, mode_d, opa_d, opb_d, cin_d, opv_d} = {h_cmd, h_mode, h_opa, h_opb, h_cin, h_opv};
        cnt_d   = is_mul(h_mode, h_cmd) ? CW'(MUL_LAT) : CW'(BASE_LAT);
        ce_d    = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      // The counter holds through ISSUE so the cnt==1 cycle lands at ISSUE+LAT.
      WAIT: if (cnt_q == CW'(1)) begin
        rsp_res_d   = ALU_RES;
        rsp_flags_d = in_flags;
        rsp_valid_d = 1'b1;
        ce_d        = 1'b0;
        state_d     = HOLD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      HOLD: if (RSP_READY) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      cin_q       <= 1'b0;
      opv_q       <= '0;
      ce_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      mode_q      <= mode_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cin_q       <= cin_d;
      opv_q       <= opv_d;
      ce_q        <= ce_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign ALU_CMD   = cmd_q;
  assign ALU_MODE  = mode_q;
  assign ALU_OPA   = opa_q;
  assign ALU_OPB   = opb_q;
  assign ALU_CIN   = cin_q;
  assign ALU_VALID = opv_q;
  assign ALU_CE    = ce_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RES   = rsp_res_q;
  assign {RSP_ERR, RSP_OFLOW, RSP_COUT, RSP_G, RSP_L, RSP_E} = rsp_flags_q;
endmodule
